// File: rtl/add_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
package add_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Guarded so an illegal CHUNK reaches the elaboration check, not a divide-by-zero.
    function automatic int calc_stages(input int width, input int chunk);
        if (chunk < 1) begin
            return 1;
        end
        return width / chunk;
    endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit ripple-carry slice; c_msb is the carry into the top bit.
module add_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] sum,
    output logic             c_out,
    output logic             c_msb
);

    logic [CHUNK:0] carry;

    assign carry[0] = c_in;

    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
        assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
        assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end

    assign c_out = carry[CHUNK];
    assign c_msb = carry[CHUNK-1];

endmodule

// File: rtl/add_pipe.sv
// Pipelined add/sub: one CHUNK-bit ripple slice per stage, carry registered between
// stages, global-stall valid/ready handshake, carry/overflow/zero flags.
module add_pipe
    import add_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_c,
    input  logic             in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_c,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    if ((CHUNK < 1) || ((WIDTH % ((CHUNK < 1) ? 1 : CHUNK)) != 0)) begin : g_bad_cfg
        $error("add_pipe: WIDTH must be a positive multiple of CHUNK");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c_first;

    logic             valid_reg [STAGES];
    logic [WIDTH-1:0] a_reg     [STAGES];
    logic [WIDTH-1:0] b_reg     [STAGES];
    logic [WIDTH-1:0] sum_reg   [STAGES];
    logic             c_reg     [STAGES];
    logic             ovf_reg;
    logic             zero_reg;

    // Whole pipe moves together; a full output rank that is not taken freezes everything.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign b_eff   = (in_op == OP_SUB) ? ~in_b : in_b;
    assign c_first = (in_op == OP_SUB) ? 1'b1 : in_c;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_rank
        localparam int LO = CHUNK * gi;

        logic [WIDTH-1:0] a_prev;
        logic [WIDTH-1:0] b_prev;
        logic [WIDTH-1:0] sum_prev;
        logic [WIDTH-1:0] sum_next;
        logic             valid_prev;
        logic             c_ch;
        logic [CHUNK-1:0] s_ch;
        logic             co_ch;
        logic             cm_ch;

        if (gi == 0) begin : g_src
            assign a_prev     = in_a;
            assign b_prev     = b_eff;
            assign sum_prev   = '0;
            assign valid_prev = in_valid;
            assign c_ch       = c_first;
        end else begin : g_src
            assign a_prev     = a_reg[gi-1];
            assign b_prev     = b_reg[gi-1];
            assign sum_prev   = sum_reg[gi-1];
            assign valid_prev = valid_reg[gi-1];
            assign c_ch       = c_reg[gi-1];
        end

        add_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a     (a_prev[LO +: CHUNK]),
            .b     (b_prev[LO +: CHUNK]),
            .c_in  (c_ch),
            .sum   (s_ch),
            .c_out (co_ch),
            .c_msb (cm_ch)
        );

        always_comb begin
            sum_next              = sum_prev;
            sum_next[LO +: CHUNK] = s_ch;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_reg[gi] <= 1'b0;
                a_reg[gi]     <= '0;
                b_reg[gi]     <= '0;
                sum_reg[gi]   <= '0;
                c_reg[gi]     <= 1'b0;
            end else if (adv) begin
                valid_reg[gi] <= valid_prev;
                a_reg[gi]     <= a_prev;
                b_reg[gi]     <= b_prev;
                sum_reg[gi]   <= sum_next;
                c_reg[gi]     <= co_ch;
            end
        end

        if (gi == STAGES - 1) begin : g_flags
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_reg  <= 1'b0;
                    zero_reg <= 1'b0;
                end else if (adv) begin
                    ovf_reg  <= cm_ch ^ co_ch;
                    zero_reg <= ~|sum_next;
                end
            end
        end
    end

    assign out_valid = valid_reg[STAGES-1];
    assign out_sum   = sum_reg[STAGES-1];
    assign out_c     = c_reg[STAGES-1];
    assign out_ovf   = ovf_reg;
    assign out_zero  = zero_reg;

endmodule

// File: tb/tb_add_pipe.sv
// Bench for add_pipe: directed table at 16/4, latency-1 instance at 16/16, stall and
// reset sequences, and a randomized 32/8 instance against a reference model.
module tb_add_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_c, in_op, out_ready;
    logic [15:0] in_a, in_b;

    logic        in_ready, out_valid, out_c, out_ovf, out_zero;
    logic [15:0] out_sum;
    logic        l_in_ready, l_out_valid, l_out_c, l_out_ovf, l_out_zero;
    logic [15:0] l_out_sum;

    logic        w_in_valid, w_in_c, w_in_op, w_out_ready;
    logic [31:0] w_in_a, w_in_b;
    logic        w_in_ready, w_out_valid, w_out_c, w_out_ovf, w_out_zero;
    logic [31:0] w_out_sum;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    add_pipe #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_c(out_c), .out_ovf(out_ovf), .out_zero(out_zero)
    );

    add_pipe #(.WIDTH(16), .CHUNK(16)) dut_one (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l_in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_op(in_op),
        .out_valid(l_out_valid), .out_ready(out_ready), .out_sum(l_out_sum),
        .out_c(l_out_c), .out_ovf(l_out_ovf), .out_zero(l_out_zero)
    );

    add_pipe #(.WIDTH(32), .CHUNK(8)) dut_wide (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_a(w_in_a), .in_b(w_in_b), .in_c(w_in_c), .in_op(w_in_op),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_sum(w_out_sum),
        .out_c(w_out_c), .out_ovf(w_out_ovf), .out_zero(w_out_zero)
    );

    typedef struct {
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [15:0] sum;
        logic        co;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Returns {carry, overflow, zero, sum}; overflow from operand/result sign rule.
    function automatic logic [34:0] ref_op(input int w, input logic op, input logic [31:0] a,
                                           input logic [31:0] b, input logic c);
        logic [31:0] mask, aa, bb, s;
        logic [32:0] full;
        logic        co, ovf;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        aa   = a & mask;
        bb   = op ? (~b & mask) : (b & mask);
        full = {1'b0, aa} + {1'b0, bb} + (op ? 33'd1 : {32'd0, c});
        s    = full[31:0] & mask;
        co   = full[w];
        ovf  = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
        return {co, ovf, (s == 32'd0), s};
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Entered and left at 1 time unit after a rising edge.
    task automatic run_one(input vec_t v, input string name);
        int edges;
        in_op = v.op; in_a = v.a; in_b = v.b; in_c = v.c;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges    = 1;
        check({name, "_lat1"}, {l_out_valid, l_out_c, l_out_ovf, l_out_zero, l_out_sum},
              {1'b1, v.co, v.ovf, v.zero, v.sum});
        while (!out_valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        check({name, "_latency"}, edges, 4);
        check({name, "_result"}, {out_c, out_ovf, out_zero, out_sum}, {v.co, v.ovf, v.zero, v.sum});
        $display("[TB] %s op=%0d a=%h b=%h c=%0d -> sum=%h c=%0d ovf=%0d zero=%0d lat=%0d",
                 name, v.op, v.a, v.b, v.c, out_sum, out_c, out_ovf, out_zero, edges);
        @(posedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] st_a [8];
        logic [15:0] st_b [8];
        logic        st_op [8];
        logic        st_c [8];
        logic [18:0] st_exp [8];
        logic [34:0] r;
        logic [18:0] cur, snap;
        logic        hold_prev, accepted, stale;
        int          sent, got, stalls;
        logic [34:0] sb [$];
        logic [34:0] exp_w;
        int          issued, done;
        logic        acc_prev;

        //            op  a         b         c  sum       co    ovf   zero
        vecs[0] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_c = 1'b0; in_op = 1'b0; out_ready = 1'b1;
        w_in_valid = 1'b0; w_in_a = '0; w_in_b = '0; w_in_c = 1'b0; w_in_op = 1'b0;
        w_out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {in_ready, out_valid, out_c, out_ovf, out_zero, out_sum},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_one(vecs[i], $sformatf("vec%0d", i));
        end

        // Eight back-to-back beats with out_ready low for three cycles mid-stream.
        for (int i = 0; i < 8; i++) begin
            st_a[i]  = 16'(16'h1357 * (i + 1));
            st_b[i]  = 16'(16'hF0E1 - 16'h0123 * i);
            st_op[i] = i[0];
            st_c[i]  = i[1];
            r = ref_op(16, st_op[i], {16'h0, st_a[i]}, {16'h0, st_b[i]}, st_c[i]);
            st_exp[i] = {r[34:32], r[15:0]};
        end
        sent = 0; got = 0; stalls = 0; hold_prev = 1'b0; snap = '0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            out_ready = !(cyc >= 6 && cyc < 9);
            if (sent < 8) begin
                in_valid = 1'b1;
                in_a = st_a[sent]; in_b = st_b[sent]; in_op = st_op[sent]; in_c = st_c[sent];
            end else begin
                in_valid = 1'b0;
            end
            #4;
            cur = {out_c, out_ovf, out_zero, out_sum};
            if (hold_prev) check("stall_hold", cur, snap);
            if (out_valid && !out_ready) begin
                stalls++;
                check("stall_in_ready", in_ready, 1'b0);
                snap = cur;
                hold_prev = 1'b1;
            end else begin
                hold_prev = 1'b0;
            end
            accepted = in_valid && in_ready;
            if (out_valid && out_ready) begin
                check($sformatf("stream_beat%0d", got), cur, st_exp[got]);
                $display("[TB] stream beat %0d sum=%h flags=%b", got, out_sum, cur[18:16]);
                got++;
            end
            @(posedge clk); #1;
            if (accepted) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("stream_count", got, 8);
        check("stall_cycles", stalls, 3);

        // Reset with three beats in flight, the oldest already on the output.
        for (int i = 0; i < 3; i++) begin
            in_op = vecs[i].op; in_a = vecs[i].a; in_b = vecs[i].b; in_c = vecs[i].c;
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_reset_valid", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("reset_async_clear", {out_valid, out_sum}, 17'h0);
        $display("[TB] mid-flight reset: out_valid=%0d out_sum=%h", out_valid, out_sum);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        stale = 1'b0;
        repeat (8) begin
            if (out_valid) stale = 1'b1;
            @(posedge clk); #1;
        end
        check("no_stale_beat", stale, 1'b0);
        run_one(vecs[3], "post_reset");

        // Wide instance: random traffic and random backpressure against the model.
        issued = 0; done = 0; acc_prev = 1'b0;
        for (int cyc = 0; cyc < 20000 && done < 3000; cyc++) begin
            w_out_ready = ($urandom_range(0, 9) < 7);
            if (!w_in_valid || acc_prev) begin
                if (issued < 3000 && $urandom_range(0, 9) < 8) begin
                    w_in_valid = 1'b1;
                    w_in_op = 1'($urandom_range(0, 1));
                    w_in_c  = 1'($urandom_range(0, 1));
                    w_in_a  = rnd32();
                    w_in_b  = rnd32();
                end else begin
                    w_in_valid = 1'b0;
                end
            end
            #4;
            acc_prev = w_in_valid && w_in_ready;
            if (acc_prev) begin
                sb.push_back(ref_op(32, w_in_op, w_in_a, w_in_b, w_in_c));
                issued++;
            end
            if (w_out_valid && w_out_ready) begin
                if (sb.size() == 0) begin
                    check("rand_unexpected_beat", 1'b1, 1'b0);
                end else begin
                    exp_w = sb.pop_front();
                    check($sformatf("rand_beat%0d", done),
                          {w_out_c, w_out_ovf, w_out_zero, w_out_sum}, exp_w);
                end
                done++;
            end
            @(posedge clk); #1;
        end
        w_in_valid = 1'b0;
        check("rand_done", done, 3000);
        $display("[TB] wide random: %0d beats checked", done);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
